muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers, for the MIPS datapath. It replaces the single-cycle combinational multiply path in the ALU. It adds signed and unsigned multiply, signed and unsigned divide, and MTHI/MTLO writes. It exposes a busy/done handshake so the control unit can stall MFHI/MFLO and further mul/div instructions until the result is ready.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only while busy=0
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
b  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress; start ignored
done  output  1  one-cycle pulse when HI/LO receive a mul/div result
div_by_zero  output  1  valid with done; set if a DIV/DIVU had b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state goes to IDLE.
  - hi, lo, busy, done and div_by_zero all go to 0.
  - Any in-flight operation is discarded with no partial HI/LO update.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op 0-3: latch magnitudes |a| and |b|, the operand signs and the op. Load the counter with WIDTH, then go to RUN; busy=1 from the next cycle.
  - For MULTU and DIVU the magnitudes are the raw operands.
- MTHI/MTLO: start=1 with op 4 (or 5) in IDLE writes a into hi (or lo) at that edge.
  - No busy, no done; the other register is unchanged.
- op 6-7: ignored, no state change.
- RUN: exactly WIDTH cycles, counter decrements each cycle.
  - Multiply: radix-2 shift-add on a 2*WIDTH-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits.
  - Counter reaching 1 moves the FSM to FIX.
- FIX: one cycle.
  - Apply sign correction and write hi/lo; busy drops to 0 and done=1 for exactly that following cycle.
  - div_by_zero is valid during done and cleared at the next edge.
- Latency: with the accept edge as E0, hi/lo are updated at edge E(WIDTH+1), and busy is high for WIDTH+1 cycles.
  - done is high in the cycle after E(WIDTH+1); a new start can be accepted at that edge.
- During busy:
  - hi/lo keep their previous values.
  - start is ignored for all ops, including MTHI/MTLO.
- Multiply results: hi:lo = full 2*WIDTH-bit product.
  - MULT is signed: the product is negated if the operand signs differ.
- Divide results: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- Signed overflow: MIN / -1 gives lo = MIN, hi = 0, div_by_zero=0.
- Divide by zero (b=0, DIV or DIVU): same latency; lo = all ones, hi = a (raw), div_by_zero=1 with done.
- Operands a/b may change after the accept edge without affecting the result.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> at E33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles; done one pulse.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=7, b=2 -> lo=3, hi=1.
- Boundary divides:
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
  - DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 during done.
- Handshake checks:
  - MTHI a=0x1234 in IDLE -> hi=0x1234 after one edge, busy and done stay 0.
  - MTLO asserted while a MULT is busy -> ignored; lo equals the product at completion.
  - Back-to-back start at the done cycle is accepted.
- Reset mid-operation:
  - Assert reset at cycle 10 of a MULT -> next cycle busy=0, hi=lo=0, no done.
  - A new start is accepted right after reset deasserts.
  - Repeat the MULT, DIV and divide-by-zero cases with WIDTH=8 (latency 9 cycles).

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Multiply uses radix-2 shift-add and divide uses restoring division.
// Both take WIDTH iteration cycles plus one sign-fix cycle.
// busy/done let the control unit stall HI/LO readers and new mul/div requests.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  // Two's-complement negation of a 2*WIDTH-bit value.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + ONE_2W;
  endfunction

  // Unsigned magnitude; MIN maps to 2^(WIDTH-1), which is exact as an unsigned value.
  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic is_neg);
    return is_neg ? neg_w(v) : v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;   // product / quotient must be negated
  logic               neg_rem_q, neg_rem_d;   // remainder must be negated (dividend sign)
  logic               dz_pend_q, dz_pend_d;   // latched divisor-is-zero flag
  // Multiply: {partial product, multiplier}. Divide: lower half holds dividend
  // bits shifting out at the top and quotient bits shifting in at the bottom.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;           // partial remainder
  logic [WIDTH-1:0]   opnd_q, opnd_d;         // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;       // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               op_signed_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_acc_s;
  logic [WIDTH+1:0]   div_trial_s;
  logic               div_ge_s;
  logic [WIDTH:0]     div_rem_s;
  logic [WIDTH-1:0]   div_quo_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // Operand conditioning at accept time: signs and magnitudes of a and b.
  always_comb begin
    op_signed_s = (op == OP_MULT) || (op == OP_DIV);
    a_neg_s     = op_signed_s & a[WIDTH-1];
    b_neg_s     = op_signed_s & b[WIDTH-1];
    a_mag_s     = mag_w(a, a_neg_s);
    b_mag_s     = mag_w(b, b_neg_s);
  end

  // One iteration step of each algorithm, plus the sign-corrected final results.
  always_comb begin
    // Shift-add: conditionally add multiplicand to the upper half, then shift the
    // whole accumulator right so the carry lands in the top bit.
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    mul_acc_s = {mul_sum_s, acc_q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder and trial-subtract
    // the divisor; a clear sign bit means the subtraction is kept.
    div_trial_s = {rem_q, acc_q[WIDTH-1]} - {2'b00, opnd_q};
    div_ge_s    = ~div_trial_s[WIDTH+1];
    if (div_ge_s) begin
      div_rem_s = div_trial_s[WIDTH:0];
    end else begin
      div_rem_s = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    end
    div_quo_s = {acc_q[WIDTH-2:0], div_ge_s};

    prod_fix_s = neg_res_q ? neg_2w(acc_q) : acc_q;
    quo_fix_s  = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix_s  = neg_rem_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
  end

  // Next-state logic for the IDLE/RUN/FIX sequencer and all datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = op[1];
              neg_res_d = a_neg_s ^ b_neg_s;
              neg_rem_d = a_neg_s;
              dz_pend_d = op[1] & (b == ZERO_W);
              a_raw_d   = a;
              rem_d     = {(WIDTH+1){1'b0}};
              cnt_d     = CNT_LOAD;
              busy_d    = 1'b1;
              state_d   = ST_RUN;
              if (op[1]) begin
                opnd_d = b_mag_s;
                acc_d  = {ZERO_W, a_mag_s};
              end else begin
                opnd_d = a_mag_s;
                acc_d  = {ZERO_W, b_mag_s};
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (is_div_q) begin
          acc_d = {ZERO_W, div_quo_s};
          rem_d = div_rem_s;
        end else begin
          acc_d = mul_acc_s;
        end
        if (cnt_q == CNT_ONE) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end else if (dz_pend_q) begin
          hi_d = a_raw_q;
          lo_d = ONES_W;
        end else begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end
        dz_d    = is_div_q & dz_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      acc_q     <= {(2*WIDTH){1'b0}};
      rem_q     <= {(WIDTH+1){1'b0}};
      opnd_q    <= ZERO_W;
      a_raw_q   <= ZERO_W;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Each issued mul/div pushes its expected {div_by_zero, hi, lo} into a queue.
// A per-instance monitor pops and compares on every done pulse.
// The same monitor checks that busy stayed high for WIDTH+1 cycles.
module tb_muldiv_unit;

  logic clk;
  logic reset;

  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  logic [64:0] q32[$];
  logic [64:0] q8[$];
  int   bcnt32 = 0;
  int   bcnt8  = 0;
  logic prev_done32 = 1'b0;
  logic prev_done8  = 1'b0;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_by_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (done32) begin
      chk("busy_len32", 65'(bcnt32), 65'd33);
      chk("done_pulse32", 65'(prev_done32), 65'd0);
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done32: got done with no pending op, expected none");
      end else begin
        chk("result32", {dz32, hi32, lo32}, q32.pop_front());
      end
    end
    if (dz32 && !done32) begin
      checks++;
      errors++;
      $display("FAIL dz_without_done32: got div_by_zero=1 expected 0");
    end
    prev_done32 = done32;
    bcnt32 = busy32 ? bcnt32 + 1 : 0;
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      chk("busy_len8", 65'(bcnt8), 65'd9);
      chk("done_pulse8", 65'(prev_done8), 65'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done with no pending op, expected none");
      end else begin
        chk("result8", 65'({dz8, hi8, lo8}), q8.pop_front());
      end
    end
    if (dz8 && !done8) begin
      checks++;
      errors++;
      $display("FAIL dz_without_done8: got div_by_zero=1 expected 0");
    end
    prev_done8 = done8;
    bcnt8 = busy8 ? bcnt8 + 1 : 0;
  end

  // Called just after a falling edge; the request is accepted at the next rising edge.
  task automatic issue32(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
    if (o < 3'd4) q32.push_back({edz, eh, el});
    start32 = 1'b1; op32 = o; a32 = av; b32 = bv;
    @(posedge clk);
    #1;
    start32 = 1'b0; op32 = 3'd7; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eh, input logic [7:0] el, input logic edz);
    if (o < 3'd4) q8.push_back(65'({edz, eh, el}));
    start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
    @(posedge clk);
    #1;
    start8 = 1'b0; op8 = 3'd7; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Returns at the falling edge where done is seen, or flags a timeout.
  task automatic wait_done32();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done32 && n < 60);
    if (!done32) begin
      checks++;
      errors++;
      $display("FAIL timeout32: got no done in %0d cycles, expected done", n);
    end
  endtask

  task automatic wait_done8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 30);
    if (!done8) begin
      checks++;
      errors++;
      $display("FAIL timeout8: got no done in %0d cycles, expected done", n);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start32 = 1'b0; op32 = 3'd7; a32 = 32'd0; b32 = 32'd0;
    start8  = 1'b0; op8  = 3'd7; a8  = 8'd0;  b8  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state32", {busy32, done32, dz32, hi32, lo32}, 67'd0);
    chk("reset_state8", 65'({busy8, done8, dz8, hi8, lo8}), 65'd0);
    reset = 1'b0;

    // MTHI / MTLO / no-op in IDLE.
    issue32(3'd4, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("mthi", {busy32, done32, hi32, lo32}, {2'b00, 32'h0000_1234, 32'h0});
    issue32(3'd5, 32'h0000_5678, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("mtlo", {busy32, done32, hi32, lo32}, {2'b00, 32'h0000_1234, 32'h0000_5678});
    issue32(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("noop", {busy32, done32, hi32, lo32}, {2'b00, 32'h0000_1234, 32'h0000_5678});

    // MULT -3 * 7 with an MTLO attempted while busy.
    issue32(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_while_busy", {busy32, hi32, lo32}, {1'b1, 32'h0000_1234, 32'h0000_5678});
    start32 = 1'b1; op32 = 3'd5; a32 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    wait_done32();

    // Back-to-back requests, each issued in the done cycle of the previous one.
    issue32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done32();
    issue32(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done32();
    issue32(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    wait_done32();
    issue32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    wait_done32();
    issue32(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_done32();
    issue32(3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    wait_done32();
    issue32(3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
    wait_done32();
    issue32(3'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0);
    wait_done32();
    issue32(3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b0);
    wait_done32();
    issue32(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    wait_done32();

    // Reset in the middle of a MULT, then an immediate new request.
    @(negedge clk);
    issue32(3'd0, 32'h0000_1234, 32'h10, 32'd0, 32'h0001_2340, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    q32.delete();
    @(negedge clk);
    chk("reset_midop", {busy32, done32, hi32, lo32}, 66'd0);
    reset = 1'b0;
    issue32(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_done32();

    // WIDTH=8 instance: multiply, divide and boundary cases.
    @(negedge clk);
    issue8(3'd0, 8'hFD, 8'h07, 8'hFF, 8'hEB, 1'b0);
    wait_done8();
    issue8(3'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    wait_done8();
    issue8(3'd2, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0);
    wait_done8();
    issue8(3'd3, 8'h05, 8'h00, 8'h05, 8'hFF, 1'b1);
    wait_done8();
    issue8(3'd2, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    wait_done8();

    repeat (3) @(negedge clk);
    chk("q32_drained", 65'(q32.size()), 65'd0);
    chk("q8_drained", 65'(q8.size()), 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
